// File: rtl/seat_reservation_table.sv
// rtl/seat_reservation_table.sv - per-seat reservation records with expiry scan and daily clear
module seat_reservation_table #(
    parameter int NUM_SEATS = 16,
    parameter int SEAT_W    = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [10:0]          time_in,
    input  logic                 day_rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [1:0]           req_op,
    input  logic [SEAT_W-1:0]    req_seat,
    input  logic [5:0]           req_dur,
    output logic                 rsp_valid,
    output logic [1:0]           rsp_status,
    output logic                 expire_valid,
    output logic [SEAT_W-1:0]    expire_seat,
    output logic [NUM_SEATS-1:0] seat_occupied,
    output logic [SEAT_W:0]      free_count
);

    typedef enum logic [1:0] {IDLE, SCAN, CLEAR} state_t;

    localparam logic [1:0] OP_RESERVE = 2'b00;
    localparam logic [1:0] OP_RELEASE = 2'b01;
    localparam logic [1:0] OP_EXTEND  = 2'b10;
    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_BUSY    = 2'b01;
    localparam logic [1:0] ST_NOTRES  = 2'b10;
    localparam logic [1:0] ST_BADARG  = 2'b11;

    state_t                state_q, state_d;
    logic [SEAT_W-1:0]     ptr_q, ptr_d;
    logic [10:0]           scan_time_q, scan_time_d;
    logic                  scan_pending_q, scan_pending_d;
    logic [NUM_SEATS-1:0]  occ_q, occ_d;
    logic [10:0]           exp_q [NUM_SEATS];
    logic [10:0]           exp_d [NUM_SEATS];
    logic [10:0]           time_prev_q;
    logic                  day_prev_q;
    logic                  time_chg_q, day_edge_q;
    logic                  ready_q;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [1:0]            rsp_status_q, rsp_status_d;
    logic                  expire_valid_q, expire_valid_d;
    logic [SEAT_W-1:0]     expire_seat_q, expire_seat_d;
    logic                  seat_ok, dur_ok;
    logic [SEAT_W:0]       busy_cnt;

    // Minutes are at most 59+59, so a single subtraction always normalises.
    function automatic logic [10:0] time_add(input logic [10:0] t, input logic [5:0] dur);
        logic [6:0] m;
        logic [4:0] h;
        m = {1'b0, t[5:0]} + {1'b0, dur};
        h = t[10:6];
        if (m >= 7'd60) begin
            m = m - 7'd60;
            h = h + 5'd1;
        end
        if (h >= 5'd24) h = 5'd0;
        return {h, m[5:0]};
    endfunction

    assign seat_ok = ({1'b0, req_seat} < (SEAT_W+1)'(NUM_SEATS));
    assign dur_ok  = (req_dur >= 6'd1) && (req_dur <= 6'd59);

    // Pending scan/clear triggers withdraw ready so a handshake never coincides with leaving IDLE.
    assign req_ready = ready_q & ~time_chg_q & ~day_edge_q & ~scan_pending_q;

    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        scan_time_d    = scan_time_q;
        scan_pending_d = scan_pending_q;
        occ_d          = occ_q;
        exp_d          = exp_q;
        rsp_valid_d    = 1'b0;
        rsp_status_d   = rsp_status_q;
        expire_valid_d = 1'b0;
        expire_seat_d  = expire_seat_q;
        case (state_q)
            IDLE: begin
                if (day_edge_q) begin
                    state_d = CLEAR;
                end else if (time_chg_q || scan_pending_q) begin
                    state_d        = SCAN;
                    scan_time_d    = time_in;
                    ptr_d          = '0;
                    scan_pending_d = 1'b0;
                end else if (req_valid && req_ready) begin
                    rsp_valid_d = 1'b1;
                    if (!seat_ok || req_op == 2'b11 || (req_op != OP_RELEASE && !dur_ok)) begin
                        rsp_status_d = ST_BADARG;
                    end else if (req_op == OP_RESERVE) begin
                        if (occ_q[req_seat]) begin
                            rsp_status_d = ST_BUSY;
                        end else begin
                            occ_d[req_seat] = 1'b1;
                            exp_d[req_seat] = time_add(time_in, req_dur);
                            rsp_status_d    = ST_OK;
                        end
                    end else if (!occ_q[req_seat]) begin
                        rsp_status_d = ST_NOTRES;
                    end else begin
                        if (req_op == OP_EXTEND) exp_d[req_seat] = time_add(exp_q[req_seat], req_dur);
                        else                     occ_d[req_seat] = 1'b0;
                        rsp_status_d = ST_OK;
                    end
                end
            end
            SCAN: begin
                if (day_edge_q) begin
                    state_d = CLEAR;
                end else begin
                    if (time_chg_q) scan_pending_d = 1'b1;
                    if (occ_q[ptr_q] && exp_q[ptr_q] == scan_time_q) begin
                        occ_d[ptr_q]   = 1'b0;
                        expire_valid_d = 1'b1;
                        expire_seat_d  = ptr_q;
                    end
                    if (ptr_q == SEAT_W'(NUM_SEATS - 1)) state_d = IDLE;
                    else                                  ptr_d   = ptr_q + 1'b1;
                end
            end
            CLEAR: begin
                occ_d          = '0;
                scan_pending_d = 1'b0;
                state_d        = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            scan_time_q    <= '0;
            scan_pending_q <= 1'b0;
            occ_q          <= '0;
            for (int i = 0; i < NUM_SEATS; i++) exp_q[i] <= '0;
            time_prev_q    <= '0;
            day_prev_q     <= 1'b0;
            time_chg_q     <= 1'b0;
            day_edge_q     <= 1'b0;
            ready_q        <= 1'b1;
            rsp_valid_q    <= 1'b0;
            rsp_status_q   <= 2'b00;
            expire_valid_q <= 1'b0;
            expire_seat_q  <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            scan_time_q    <= scan_time_d;
            scan_pending_q <= scan_pending_d;
            occ_q          <= occ_d;
            exp_q          <= exp_d;
            time_prev_q    <= time_in;
            day_prev_q     <= day_rst;
            time_chg_q     <= (time_in != time_prev_q);
            day_edge_q     <= day_rst & ~day_prev_q;
            ready_q        <= (state_d == IDLE);
            rsp_valid_q    <= rsp_valid_d;
            rsp_status_q   <= rsp_status_d;
            expire_valid_q <= expire_valid_d;
            expire_seat_q  <= expire_seat_d;
        end
    end

    always_comb begin
        busy_cnt = '0;
        for (int i = 0; i < NUM_SEATS; i++) busy_cnt = busy_cnt + (SEAT_W+1)'(occ_q[i]);
    end

    assign free_count    = (SEAT_W+1)'(NUM_SEATS) - busy_cnt;
    assign seat_occupied = occ_q;
    assign rsp_valid     = rsp_valid_q;
    assign rsp_status    = rsp_status_q;
    assign expire_valid  = expire_valid_q;
    assign expire_seat   = expire_seat_q;

endmodule

// File: tb/tb_seat_reservation_table.sv
// tb/tb_seat_reservation_table.sv - scoreboard bench for seat_reservation_table
module tb_seat_reservation_table;
    localparam int NS = 16;
    localparam int SW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [10:0]   time_in = '0;
    logic          day_rst = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic [1:0]    req_op = '0;
    logic [SW-1:0] req_seat = '0;
    logic [5:0]    req_dur = '0;
    logic          rsp_valid;
    logic [1:0]    rsp_status;
    logic          expire_valid;
    logic [SW-1:0] expire_seat;
    logic [NS-1:0] seat_occupied;
    logic [SW:0]   free_count;

    seat_reservation_table #(.NUM_SEATS(NS), .SEAT_W(SW)) dut (
        .clk(clk), .rst_n(rst_n), .time_in(time_in), .day_rst(day_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_seat(req_seat), .req_dur(req_dur), .rsp_valid(rsp_valid),
        .rsp_status(rsp_status), .expire_valid(expire_valid),
        .expire_seat(expire_seat), .seat_occupied(seat_occupied),
        .free_count(free_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            status;
        logic [NS-1:0] map;
    } rsp_t;

    rsp_t rsp_q[$];
    int   expq[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   m_occ [NS];
    int   m_exp [NS];
    int   cur_min;
    rsp_t mon_r;
    int   mon_s;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [10:0] enc(input int m);
        return {5'(m / 60), 6'(m % 60)};
    endfunction

    function automatic logic [NS-1:0] model_map();
        logic [NS-1:0] v;
        for (int i = 0; i < NS; i++) v[i] = m_occ[i];
        return v;
    endfunction

    function automatic int model_exec(input int op, input int seat, input int dur);
        if (seat >= NS || op == 3 || (op != 1 && (dur < 1 || dur > 59))) return 3;
        if (op == 0) begin
            if (m_occ[seat]) return 1;
            m_occ[seat] = 1'b1;
            m_exp[seat] = (cur_min + dur) % 1440;
            return 0;
        end
        if (!m_occ[seat]) return 2;
        if (op == 1) m_occ[seat] = 1'b0;
        else         m_exp[seat] = (m_exp[seat] + dur) % 1440;
        return 0;
    endfunction

    // Independent response/expiry monitor
    always @(negedge clk) begin
        if (rst_n) begin
            if (rsp_valid) begin
                if (rsp_q.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    mon_r = rsp_q.pop_front();
                    chk("rsp_status", rsp_status, mon_r.status);
                    chk("rsp_bitmap", seat_occupied, mon_r.map);
                    chk("rsp_free_count", free_count, NS - $countones(mon_r.map));
                end
            end
            if (expire_valid) begin
                if (expq.size() == 0) begin
                    chk("expire_unexpected", expire_seat, 999);
                end else begin
                    mon_s = expq.pop_front();
                    chk("expire_seat", expire_seat, mon_s);
                    chk("expire_cleared", seat_occupied[expire_seat], 0);
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_req(input int op, input int seat, input int dur);
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = 2'(op);
        req_seat  = SW'(seat);
        req_dur   = 6'(dur);
    endtask

    task automatic wait_accept();
        int   n;
        rsp_t r;
        n = 0;
        #1;
        while (!req_ready && n < 300) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!req_ready) begin
            chk("accept_timeout", 0, 1);
            req_valid = 1'b0;
            return;
        end
        r.status = model_exec(int'(req_op), int'(req_seat), int'(req_dur));
        r.map    = model_map();
        rsp_q.push_back(r);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic send(input int op, input int seat, input int dur);
        drive_req(op, seat, dur);
        wait_accept();
    endtask

    task automatic set_time(input int m, input bit apply);
        @(negedge clk);
        time_in = enc(m);
        if (m != cur_min) begin
            cur_min = m;
            if (apply) begin
                for (int i = 0; i < NS; i++) begin
                    if (m_occ[i] && m_exp[i] == m) begin
                        m_occ[i] = 1'b0;
                        expq.push_back(i);
                    end
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, req_ready, 1);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_status"}, rsp_status, 0);
        chk({tag, "_expire_valid"}, expire_valid, 0);
        chk({tag, "_expire_seat"}, expire_seat, 0);
        chk({tag, "_seat_occupied"}, seat_occupied, 0);
        chk({tag, "_free_count"}, free_count, NS);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int c, m, s, r;
        for (int i = 0; i < NS; i++) begin m_occ[i] = 1'b0; m_exp[i] = 0; end
        cur_min = 480;
        time_in = enc(480);
        idle(3);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        idle(NS + 8);

        // Basic reserve and busy
        send(0, 3, 30);
        send(0, 3, 30);
        idle(2);
        chk("free_after_reserve", free_count, NS - 1);

        // Expiry at 08:30, none at 08:29
        set_time(509, 1);
        idle(NS + 6);
        chk("seat3_held_0829", seat_occupied[3], 1);
        set_time(510, 1);
        idle(NS + 6);
        chk("seat3_released_0830", seat_occupied[3], 0);

        // Midnight wrap and extend with hour carry
        set_time(1430, 1);
        idle(NS + 6);
        send(0, 5, 15);
        set_time(5, 1);
        idle(NS + 6);
        set_time(565, 1);
        idle(NS + 6);
        send(0, 7, 20);
        send(2, 7, 20);
        set_time(604, 1);
        idle(NS + 6);
        chk("seat7_held_1004", seat_occupied[7], 1);
        set_time(605, 1);
        idle(NS + 6);

        // Argument errors and not-reserved
        send(0, 16, 10);
        send(2, 17, 10);
        send(0, 1, 0);
        send(0, 1, 60);
        send(1, 2, 5);
        send(2, 2, 5);
        send(3, 1, 5);

        // Fill, then daily clear in the middle of a scan with a held request
        for (int i = 0; i < NS; i++) send(0, i, 10 + i);
        set_time((cur_min + 1) % 1440, 1);
        idle(4);
        #1;
        chk("ready_low_scan", req_ready, 0);
        drive_req(0, 4, 10);
        day_rst = 1'b1;
        for (int i = 0; i < NS; i++) m_occ[i] = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            chk("ready_low_clear", req_ready, 0);
        end
        @(negedge clk);
        #1;
        chk("cleared_bitmap", seat_occupied, 0);
        chk("cleared_free", free_count, NS);
        wait_accept();
        day_rst = 1'b0;
        idle(4);

        // Two time changes during one scan: only the latest is rescanned
        c = cur_min;
        send(0, 8, 5);
        send(0, 9, 6);
        set_time((c + 2) % 1440, 1);
        idle(3);
        set_time((c + 5) % 1440, 0);
        idle(3);
        set_time((c + 6) % 1440, 1);
        idle(2 * NS + 10);
        chk("missed_expiry_kept", seat_occupied[8], 1);
        chk("latest_expiry_done", seat_occupied[9], 0);

        // Asynchronous reset mid-scan
        set_time((cur_min + 7) % 1440, 1);
        idle(5);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midscan_reset");
        expq.delete();
        rsp_q.delete();
        for (int i = 0; i < NS; i++) m_occ[i] = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(NS + 8);

        // Randomised traffic
        repeat (220) begin
            r = $urandom_range(0, 9);
            if (r < 2) begin
                m = $urandom_range(0, 1439);
                if (r == 0) begin
                    s = $urandom_range(0, NS - 1);
                    if (m_occ[s]) m = m_exp[s];
                end
                set_time(m, 1);
                idle(NS + 6);
            end else begin
                send($urandom_range(0, 3), $urandom_range(0, NS + 1),
                     ($urandom_range(0, 9) == 0) ? $urandom_range(0, 63) : $urandom_range(1, 59));
            end
        end

        idle(NS + 8);
        chk("final_bitmap", seat_occupied, model_map());
        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("expire_queue_drained", expq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
